pkt_arb_mux: RTL and testbench

Parametrised N-input packet multiplexer that merges packet streams from several internal sources (statistics, control/config response, generator loopback) onto one output port. Each input has its own flit buffer and packet-descriptor queue; only complete packets are arbitrated. Arbitration is fixed-priority or round-robin, and packets with the valid flag cleared are discarded instead of forwarded. This is the successor to the fixed two-input port-0 mux and adds channel count, buffering, back-pressure, arbitration mode and drop accounting.

---
 rtl/pkt_arb_mux.sv | 140 ++++++++++++++
 tb/tb_pkt_arb_mux.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pkt_arb_mux.sv
// pkt_arb_mux: N-input packet mux with per-channel flit buffers, descriptor queues, arbitration and drop accounting
module pkt_arb_mux #(
  parameter int N_IN = 4,
  parameter int DW = 134,
  parameter int DEPTH = 256,
  parameter int PKT_DEPTH = 16,
  parameter int MAX_PKT_FLITS = 32,
  parameter int ARB_MODE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_IN*DW-1:0]   in_data,
  input  logic [N_IN-1:0]      in_data_wr,
  input  logic [N_IN-1:0]      in_data_valid,
  input  logic [N_IN-1:0]      in_data_valid_wr,
  output logic [N_IN-1:0]      in_data_ready,
  output logic [DW-1:0]        out_data,
  output logic                 out_data_wr,
  output logic                 out_data_valid,
  output logic                 out_data_valid_wr,
  input  logic                 out_data_ready,
  output logic [31:0]          drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(PKT_DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(N_IN);
  localparam int DL = CW + 1;
  typedef enum logic [1:0] {IDLE, SEND, DROP} state_t;
  state_t state;
  logic [N_IN*DW-1:0] rd_all;
  logic [N_IN*DL-1:0] head_all;
  logic [N_IN-1:0] d_empty, rd_en, dpop;
  logic [SW-1:0] gnt, last_grant, sel, cand;
  logic [CW-1:0] rem;
  logic [DL-1:0] hd;
  logic found, go;
  for (genvar i = 0; i < N_IN; i++) begin : g_ch
    logic [DW-1:0] mem [DEPTH];
    logic [DL-1:0] dq [PKT_DEPTH];
    logic [AW:0] wp, rp, occ;
    logic [PW:0] dwp, drp;
    logic [CW-1:0] cnt, n;
    logic bad, rdy, full, dfull, store, ovf, push, good;
    assign occ = wp - rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dfull = (dwp[PW] != drp[PW]) && (dwp[PW-1:0] == drp[PW-1:0]);
    assign store = in_data_wr[i] && !full;
    assign ovf = in_data_wr[i] && full;
    assign push = in_data_valid_wr[i] && !dfull;
    assign n = cnt + CW'(store);
    assign good = in_data_valid[i] && !bad && !ovf && (int'(n) <= MAX_PKT_FLITS);
    assign d_empty[i] = dwp == drp;
    assign head_all[i*DL +: DL] = dq[drp[PW-1:0]];
    assign rd_all[i*DW +: DW] = mem[rp[AW-1:0]];
    assign in_data_ready[i] = rdy;
    always_ff @(posedge clk) begin
      if (store) mem[wp[AW-1:0]] <= in_data[i*DW +: DW];
      if (push) dq[dwp[PW-1:0]] <= {good, n};
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        wp <= '0;
        rp <= '0;
        dwp <= '0;
        drp <= '0;
        cnt <= '0;
        bad <= 1'b0;
        rdy <= 1'b1;
      end else begin
        wp <= wp + (AW+1)'(store);
        rp <= rp + (AW+1)'(rd_en[i]);
        dwp <= dwp + (PW+1)'(push);
        drp <= drp + (PW+1)'(dpop[i]);
        cnt <= in_data_valid_wr[i] ? '0 : n;
        bad <= !in_data_valid_wr[i] && (bad || ovf);
        rdy <= (int'(occ) <= DEPTH - MAX_PKT_FLITS) && !dfull;
      end
    end
  end
  always_comb begin
    found = 1'b0;
    sel = '0;
    cand = '0;
    for (int k = 0; k < N_IN; k++) begin
      cand = SW'((ARB_MODE != 0) ? (int'(last_grant) + 1 + k) % N_IN : k);
      if (!found && !d_empty[cand]) begin
        found = 1'b1;
        sel = cand;
      end
    end
  end
  assign go = (state == IDLE) && found && out_data_ready;
  assign hd = head_all[sel*DL +: DL];
  always_comb begin
    rd_en = '0;
    dpop = '0;
    rd_en[gnt] = state != IDLE;
    dpop[sel] = go;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      last_grant <= SW'(N_IN - 1);
      rem <= '0;
      out_data <= '0;
      out_data_wr <= 1'b0;
      out_data_valid <= 1'b0;
      out_data_valid_wr <= 1'b0;
      drop_cnt <= '0;
    end else begin
      out_data_wr <= 1'b0;
      out_data_valid <= 1'b0;
      out_data_valid_wr <= 1'b0;
      case (state)
        IDLE: if (go) begin
          gnt <= sel;
          last_grant <= sel;
          rem <= hd[CW-1:0];
          if (hd[CW-1:0] == '0 || !hd[CW]) drop_cnt <= drop_cnt + 32'(~&drop_cnt);
          state <= (hd[CW-1:0] == '0) ? IDLE : hd[CW] ? SEND : DROP;
        end
        SEND: begin
          out_data <= rd_all[gnt*DW +: DW];
          out_data_wr <= 1'b1;
          out_data_valid <= rem == CW'(1);
          out_data_valid_wr <= rem == CW'(1);
          rem <= rem - CW'(1);
          state <= (rem == CW'(1)) ? IDLE : SEND;
        end
        DROP: begin
          rem <= rem - CW'(1);
          state <= (rem == CW'(1)) ? IDLE : DROP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pkt_arb_mux.sv
// tb_pkt_arb_mux: directed checks of pkt_arb_mux forwarding, drop, arbitration, back-pressure and reset
module tb_pkt_arb_mux;
  localparam int N = 4;
  localparam int DW = 134;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0] in_data_wr = '0;
  logic [N-1:0] in_data_valid = '0;
  logic [N-1:0] in_data_valid_wr = '0;
  logic out_data_ready = 1'b0;
  logic [N-1:0] rdy_a, rdy_b;
  logic [DW-1:0] od_a, od_b;
  logic wr_a, wr_b, v_a, v_b, vwr_a, vwr_b;
  logic [31:0] drop_a, drop_b;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  typedef struct packed {logic [31:0] cyc; logic [DW-1:0] d; logic v; logic vwr;} rec_t;
  rec_t qa[$];
  rec_t qb[$];
  pkt_arb_mux #(.N_IN(N), .DW(DW), .DEPTH(64), .PKT_DEPTH(16), .MAX_PKT_FLITS(32), .ARB_MODE(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_data_wr(in_data_wr), .in_data_valid(in_data_valid),
    .in_data_valid_wr(in_data_valid_wr), .in_data_ready(rdy_a), .out_data(od_a), .out_data_wr(wr_a),
    .out_data_valid(v_a), .out_data_valid_wr(vwr_a), .out_data_ready(out_data_ready), .drop_cnt(drop_a));
  pkt_arb_mux #(.N_IN(N), .DW(DW), .DEPTH(64), .PKT_DEPTH(16), .MAX_PKT_FLITS(32), .ARB_MODE(0)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_data_wr(in_data_wr), .in_data_valid(in_data_valid),
    .in_data_valid_wr(in_data_valid_wr), .in_data_ready(rdy_b), .out_data(od_b), .out_data_wr(wr_b),
    .out_data_valid(v_b), .out_data_valid_wr(vwr_b), .out_data_ready(out_data_ready), .drop_cnt(drop_b));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (wr_a) qa.push_back({32'(cyc), od_a, v_a, vwr_a});
    if (wr_b) qb.push_back({32'(cyc), od_b, v_b, vwr_b});
  end
  function automatic logic [DW-1:0] flit(input int ch, input int pid, input int k, input int n);
    logic [1:0] tag;
    tag = (n == 1) ? 2'b11 : (k == 0) ? 2'b01 : (k == n - 1) ? 2'b10 : 2'b00;
    return {tag, (DW-2)'(ch * 65536 + pid * 256 + k)};
  endfunction
  function automatic rec_t ga(input int i);
    return (i < qa.size()) ? qa[i] : '0;
  endfunction
  function automatic rec_t gb(input int i);
    return (i < qb.size()) ? qb[i] : '0;
  endfunction
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_data_wr = '0;
    in_data_valid_wr = '0;
    in_data_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    qa.delete();
    qb.delete();
  endtask
  task automatic push_pkt(input int ch, input int n, input bit v, input int pid, output int eop);
    eop = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_data[ch*DW +: DW] = flit(ch, pid, k, n);
      in_data_wr = '0;
      in_data_wr[ch] = 1'b1;
      in_data_valid_wr = '0;
      in_data_valid_wr[ch] = (k == n - 1);
      in_data_valid[ch] = v;
      eop = cyc;
    end
    @(negedge clk);
    in_data_wr = '0;
    in_data_valid_wr = '0;
  endtask
  initial begin
    int c;
    int e;
    rec_t r;
    do_reset();
    @(negedge clk);
    chk("rst_out_data", od_a, '0);
    chk("rst_out_wr", wr_a, 0);
    chk("rst_out_valid", v_a, 0);
    chk("rst_out_valid_wr", vwr_a, 0);
    chk("rst_in_ready", rdy_a, 4'hf);
    chk("rst_in_ready_b", rdy_b, 4'hf);
    chk("rst_drop", drop_a, 0);
    out_data_ready = 1'b1;
    push_pkt(0, 4, 1'b1, 1, c);
    repeat (10) @(negedge clk);
    chk("single_count", qa.size(), 4);
    for (int k = 0; k < 4; k++) begin
      r = ga(k);
      chk($sformatf("single_data%0d", k), r.d, flit(0, 1, k, 4));
      chk($sformatf("single_cyc%0d", k), r.cyc, c + 3 + k);
      chk($sformatf("single_vwr%0d", k), r.vwr, k == 3);
      chk($sformatf("single_v%0d", k), r.v, k == 3);
    end
    qa.delete();
    qb.delete();
    push_pkt(2, 3, 1'b0, 2, c);
    repeat (8) @(negedge clk);
    chk("drop_no_out", qa.size(), 0);
    chk("drop_cnt_a", drop_a, 1);
    chk("drop_cnt_b", drop_b, 1);
    push_pkt(2, 2, 1'b1, 3, c);
    repeat (8) @(negedge clk);
    chk("drop_after_count", qa.size(), 2);
    r = ga(0);
    chk("drop_after_d0", r.d, flit(2, 3, 0, 2));
    r = ga(1);
    chk("drop_after_d1", r.d, flit(2, 3, 1, 2));
    chk("drop_after_vwr", r.vwr, 1);
    do_reset();
    out_data_ready = 1'b0;
    for (int p = 0; p < 3; p++)
      for (int ch = 0; ch < 4; ch++)
        push_pkt(ch, 2, 1'b1, p, c);
    repeat (3) @(negedge clk);
    chk("arb_hold", qa.size(), 0);
    out_data_ready = 1'b1;
    repeat (50) @(negedge clk);
    chk("rr_count", qa.size(), 24);
    chk("fp_count", qb.size(), 24);
    for (int j = 0; j < 12; j++)
      for (int k = 0; k < 2; k++) begin
        r = ga(2 * j + k);
        chk($sformatf("rr_p%0d_f%0d", j, k), r.d, flit(j % 4, j / 4, k, 2));
        r = gb(2 * j + k);
        chk($sformatf("fp_p%0d_f%0d", j, k), r.d, flit(j / 3, j % 3, k, 2));
      end
    do_reset();
    out_data_ready = 1'b0;
    push_pkt(1, 4, 1'b1, 0, c);
    push_pkt(1, 3, 1'b1, 1, c);
    repeat (5) @(negedge clk);
    chk("bp_blocked", qa.size(), 0);
    out_data_ready = 1'b1;
    @(negedge clk);
    out_data_ready = 1'b0;
    repeat (12) @(negedge clk);
    chk("bp_first_count", qa.size(), 4);
    for (int k = 0; k < 4; k++) begin
      r = ga(k);
      chk($sformatf("bp_first_d%0d", k), r.d, flit(1, 0, k, 4));
    end
    chk("bp_first_vwr", r.vwr, 1);
    out_data_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("bp_second_count", qa.size(), 7);
    for (int k = 0; k < 3; k++) begin
      r = ga(4 + k);
      chk($sformatf("bp_second_d%0d", k), r.d, flit(1, 1, k, 3));
    end
    chk("bp_second_vwr", r.vwr, 1);
    do_reset();
    out_data_ready = 1'b0;
    push_pkt(3, 32, 1'b1, 0, c);
    @(negedge clk);
    chk("full_ready_at_32", rdy_a[3], 1);
    push_pkt(3, 1, 1'b1, 1, c);
    @(negedge clk);
    chk("full_ready_low", rdy_a[3], 0);
    chk("full_ready_other", rdy_a[0], 1);
    out_data_ready = 1'b1;
    repeat (45) @(negedge clk);
    chk("full_ready_back", rdy_a[3], 1);
    chk("full_count", qa.size(), 33);
    r = ga(31);
    chk("full_p0_last_d", r.d, flit(3, 0, 31, 32));
    chk("full_p0_last_vwr", r.vwr, 1);
    r = ga(32);
    chk("full_p1_d", r.d, flit(3, 1, 0, 1));
    chk("full_p1_vwr", r.vwr, 1);
    do_reset();
    out_data_ready = 1'b1;
    push_pkt(0, 33, 1'b1, 5, c);
    repeat (45) @(negedge clk);
    chk("oversize_no_out", qa.size(), 0);
    chk("oversize_drop", drop_a, 1);
    do_reset();
    out_data_ready = 1'b1;
    push_pkt(0, 5, 1'b1, 7, c);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_wr", wr_a, 0);
    chk("midrst_data", od_a, '0);
    chk("midrst_vwr", vwr_a, 0);
    chk("midrst_drop", drop_a, 0);
    repeat (6) @(negedge clk);
    chk("midrst_partial", qa.size(), 2);
    e = 0;
    foreach (qa[i]) e += int'(qa[i].vwr);
    chk("midrst_no_eop", e, 0);
    r = ga(1);
    chk("midrst_flit1", r.d, flit(0, 7, 1, 5));
    qa.delete();
    push_pkt(0, 3, 1'b1, 8, c);
    repeat (8) @(negedge clk);
    chk("fresh_count", qa.size(), 3);
    for (int k = 0; k < 3; k++) begin
      r = ga(k);
      chk($sformatf("fresh_d%0d", k), r.d, flit(0, 8, k, 3));
    end
    chk("fresh_vwr", r.vwr, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
